// File: rtl/key_debounce_buffer.sv
// ---- key_debounce_buffer: window-based key debouncer with 4-digit entry buffer ----
// ---- rev 1.0 ----------------------------------------------------------------------
`default_nettype none

module key_debounce_buffer #(
  parameter int DEBOUNCE_WIN = 5
) (
  input  logic        clk_1khz,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  key_in,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] digits,
  output logic [2:0]  digit_cnt,
  output logic        busy
);

  localparam logic [3:0] C_WIN       = 4'(DEBOUNCE_WIN);
  localparam logic [3:0] C_CLEAR_KEY = 4'hF;
  localparam logic [2:0] C_MAX_DIG   = 3'd4;

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_HELD         = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  logic [1:0]  r_wcnt;
  logic        r_hit;
  logic [3:0]  r_wcode;
  logic        r_conflict;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [3:0]  r_dcnt;
  logic [3:0]  w_dcnt_nxt;
  logic [3:0]  r_cand;
  logic [3:0]  w_cand_nxt;
  logic        w_confirm;
  logic        w_busy;

  logic        r_key_valid;
  logic [3:0]  r_key_code;
  logic [15:0] r_digits;
  logic [2:0]  r_digit_cnt;

  // Window summary including the current cycle, so the wcnt=3 inputs count.
  logic        w_hit;
  logic [3:0]  w_code;
  logic        w_conflict;
  logic        w_win_end;
  logic        w_empty;
  logic [3:0]  w_dcnt_inc;

  assign w_hit      = r_hit | en;
  assign w_code     = r_hit ? r_wcode : key_in;
  assign w_conflict = r_conflict | (r_hit & en & (key_in != r_wcode));
  assign w_win_end  = (r_wcnt == 2'd3);
  assign w_empty    = ~w_hit;
  assign w_dcnt_inc = r_dcnt + 4'd1;

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      r_wcnt     <= 2'd0;
      r_hit      <= 1'b0;
      r_wcode    <= 4'd0;
      r_conflict <= 1'b0;
    end else begin
      r_wcnt <= r_wcnt + 2'd1;
      if (w_win_end) begin
        r_hit      <= 1'b0;
        r_wcode    <= 4'd0;
        r_conflict <= 1'b0;
      end else begin
        r_hit      <= w_hit;
        r_wcode    <= w_code;
        r_conflict <= w_conflict;
      end
    end
  end

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dcnt  <= 4'd0;
      r_cand  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_cand_nxt  = r_cand;
    w_confirm   = 1'b0;
    if (w_win_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_hit && !w_conflict) begin
            w_cand_nxt = w_code;
            w_dcnt_nxt = 4'd1;
            if (C_WIN == 4'd1) begin
              w_state_nxt = S_HELD;
              w_confirm   = 1'b1;
            end else begin
              w_state_nxt = S_PRESS_WAIT;
            end
          end
        end
        S_PRESS_WAIT: begin
          if (w_empty) begin
            w_state_nxt = S_IDLE;
            w_dcnt_nxt  = 4'd0;
          end else if (w_conflict) begin
            w_dcnt_nxt = 4'd0;
          end else if (w_code == r_cand) begin
            w_dcnt_nxt = w_dcnt_inc;
            if (w_dcnt_inc == C_WIN) begin
              w_state_nxt = S_HELD;
              w_confirm   = 1'b1;
            end
          end else begin
            w_cand_nxt = w_code;
            w_dcnt_nxt = 4'd1;
          end
        end
        S_HELD: begin
          if (w_empty) begin
            w_dcnt_nxt  = 4'd1;
            w_state_nxt = (C_WIN == 4'd1) ? S_IDLE : S_RELEASE_WAIT;
          end
        end
        S_RELEASE_WAIT: begin
          // Any key activity here is release bounce: resume HELD silently.
          if (!w_empty) begin
            w_state_nxt = S_HELD;
          end else begin
            w_dcnt_nxt = w_dcnt_inc;
            if (w_dcnt_inc == C_WIN) begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_dcnt_nxt  = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
      r_digits    <= 16'd0;
      r_digit_cnt <= 3'd0;
    end else begin
      r_key_valid <= w_confirm;
      if (w_confirm) begin
        r_key_code <= w_code;
        if (w_code == C_CLEAR_KEY) begin
          r_digits    <= 16'd0;
          r_digit_cnt <= 3'd0;
        end else begin
          r_digits <= {r_digits[11:0], w_code};
          if (r_digit_cnt != C_MAX_DIG) begin
            r_digit_cnt <= r_digit_cnt + 3'd1;
          end
        end
      end
    end
  end

  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign digits    = r_digits;
  assign digit_cnt = r_digit_cnt;
  assign busy      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_buffer.sv
// ---- tb_key_debounce_buffer: window-table stimulus with key_valid scoreboard ----
`default_nettype none

module tb_key_debounce_buffer;

  logic        clk_1khz = 1'b0;
  logic        rst      = 1'b1;
  logic        en       = 1'b0;
  logic [3:0]  key_in   = 4'd0;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic [2:0]  digit_cnt;
  logic        busy;

  key_debounce_buffer #(.DEBOUNCE_WIN(5)) dut (
    .clk_1khz  (clk_1khz),
    .rst       (rst),
    .en        (en),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digits    (digits),
    .digit_cnt (digit_cnt),
    .busy      (busy)
  );

  always #5 clk_1khz = ~clk_1khz;

  // Window kinds: 0 empty, 1 clean en@c1, 2 conflict a@c0 b@c3, 3 clean en@c3, 4 clean en every cycle
  typedef struct {
    int         kind;
    logic [3:0] a;
    logic [3:0] b;
    bit         conf;
    bit         bz;
  } win_t;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] dig;
    logic [2:0]  cnt;
    int          cyc;
  } exp_t;

  win_t        tbl[$];
  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [15:0] bm_digits = 16'd0;
  logic [2:0]  bm_cnt    = 3'd0;

  always @(posedge clk_1khz) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_1khz) begin
    if (!rst && key_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_key_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("key_code", {28'd0, key_code}, {28'd0, e.code});
        check("digits", {16'd0, digits}, {16'd0, e.dig});
        check("digit_cnt", {29'd0, digit_cnt}, {29'd0, e.cnt});
      end
    end
  end

  task automatic push_expect(input logic [3:0] code);
    exp_t e;
    if (code == 4'hF) begin
      bm_digits = 16'd0;
      bm_cnt    = 3'd0;
    end else begin
      bm_digits = {bm_digits[11:0], code};
      if (bm_cnt < 3'd4) bm_cnt = bm_cnt + 3'd1;
    end
    e.code = code;
    e.dig  = bm_digits;
    e.cnt  = bm_cnt;
    e.cyc  = cyc + 4;
    sb.push_back(e);
  endtask

  task automatic cycle(input logic e, input logic [3:0] k);
    en     = e;
    key_in = e ? k : 4'($urandom_range(0, 15));
    @(negedge clk_1khz);
  endtask

  task automatic drive_window(input int kind, input logic [3:0] a, input logic [3:0] b);
    for (int c = 0; c < 4; c++) begin
      case (kind)
        1:       cycle(c == 1, a);
        2:       cycle(c == 0 || c == 3, (c == 0) ? a : b);
        3:       cycle(c == 3, a);
        4:       cycle(1'b1, a);
        default: cycle(1'b0, a);
      endcase
    end
    en = 1'b0;
  endtask

  task automatic add(input int k, input logic [3:0] a, input logic [3:0] b, input bit c, input bit bz);
    win_t w;
    w.kind = k; w.a = a; w.b = b; w.conf = c; w.bz = bz;
    tbl.push_back(w);
  endtask

  task automatic add_release(input int n);
    for (int i = 0; i < n; i++) add(0, 4'd0, 4'd0, 1'b0, i < 4);
  endtask

  task automatic press_release(input logic [3:0] code);
    for (int i = 0; i < 5; i++) add((i == 2) ? 3 : ((i == 4) ? 4 : 1), code, 4'd0, i == 4, 1'b1);
    add_release(5);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single press of 7 held 8 windows, then 8 empty windows
    for (int i = 0; i < 8; i++) add((i % 3 == 0) ? 3 : 1, 4'd7, 4'd0, i == 4, 1'b1);
    add_release(8);
    // Press bounce on key 3
    add(1, 4'd3, 4'd0, 1'b0, 1'b1);
    add(1, 4'd3, 4'd0, 1'b0, 1'b1);
    add(0, 4'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) add(4, 4'd3, 4'd0, i == 4, 1'b1);
    add_release(6);
    // Release bounce on key 9
    for (int i = 0; i < 5; i++) add(1, 4'd9, 4'd0, i == 4, 1'b1);
    add(0, 4'd0, 4'd0, 1'b0, 1'b1);
    add(0, 4'd0, 4'd0, 1'b0, 1'b1);
    add(1, 4'd9, 4'd0, 1'b0, 1'b1);
    add_release(6);
    // Conflicting codes never confirm; clean 6 afterwards does
    for (int i = 0; i < 10; i++) add(2, 4'd2, 4'd6, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add(1, 4'd6, 4'd0, i == 4, 1'b1);
    add_release(5);
    // Conflict inside PRESS_WAIT restarts the count at zero
    add(1, 4'd4, 4'd0, 1'b0, 1'b1);
    add(1, 4'd4, 4'd0, 1'b0, 1'b1);
    add(2, 4'd4, 4'd1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) add(1, 4'd4, 4'd0, i == 4, 1'b1);
    add_release(5);
    // Candidate change reloads the count at one
    add(1, 4'd1, 4'd0, 1'b0, 1'b1);
    add(1, 4'd1, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) add(1, 4'd2, 4'd0, i == 4, 1'b1);
    add_release(5);
    // Overflow, clear key, then a fresh digit
    for (int k = 1; k <= 5; k++) press_release(4'(k));
    press_release(4'hF);
    press_release(4'd5);

    repeat (3) @(negedge clk_1khz);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    check("rst_digits", {16'd0, digits}, 32'd0);
    check("rst_digit_cnt", {29'd0, digit_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].conf) push_expect(tbl[i].a);
      drive_window(tbl[i].kind, tbl[i].a, tbl[i].b);
      check($sformatf("busy_win%0d", i), {31'd0, busy}, {31'd0, tbl[i].bz});
    end
    check("final_digits", {16'd0, digits}, 32'h0005);

    // Asynchronous reset in PRESS_WAIT with three matching windows counted
    for (int i = 0; i < 3; i++) drive_window(1, 4'd8, 4'd0);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("amid_key_valid", {31'd0, key_valid}, 32'd0);
    check("amid_key_code", {28'd0, key_code}, 32'd0);
    check("amid_digits", {16'd0, digits}, 32'd0);
    check("amid_digit_cnt", {29'd0, digit_cnt}, 32'd0);
    check("amid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk_1khz);
    rst = 1'b0;
    bm_digits = 16'd0;
    bm_cnt    = 3'd0;
    for (int i = 0; i < 4; i++) drive_window(1, 4'd8, 4'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd1);
    push_expect(4'd8);
    drive_window(1, 4'd8, 4'd0);
    for (int i = 0; i < 6; i++) drive_window(0, 4'd0, 4'd0);
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
